pixel_location_generator: RTL and testbench
===========================================

Name: pixel_location_generator

Overview:
- Raster-scan coordinate generator for the streaming image pipeline.
- Tracks the (x, y) position of the pixel on the data bus this cycle, plus a frame count.
- x/y drive the detection datapath's x and y inputs.
- Advances one pixel per enabled clock, wraps at the configured image size, and can be realigned by hsync/vsync markers from the pixel source.

Parameters:
- WIDTH, 640, pixels per line (2..65535).
- HEIGHT, 480, lines per frame (2..65535).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  pixel-valid/advance enable; when 0 all state holds.
- hsync  input  1  line-start marker: the pixel on the bus this cycle is the first pixel of a line.
- vsync  input  1  frame-start marker: the pixel on the bus this cycle is pixel (0,0) of a frame.
- x  output  16  column of current pixel, 0..WIDTH-1.
- y  output  16  row of current pixel, 0..HEIGHT-1.
- frame  output  16  completed-frame count, wraps modulo 2^16.
- eol  output  1  high when x == WIDTH-1 (combinational from x).
- eof  output  1  high when x == WIDTH-1 and y == HEIGHT-1 (combinational).

Behaviour:
- Reset (asynchronous, any time): x = 0, y = 0, frame = 0; hence eol = 0 and eof = 0. Deassertion takes effect at the next rising edge.
- x, y and frame are registers. x/y name the pixel presented in the current cycle, so the first enabled cycle after reset is pixel (0,0).
- en = 0: x, y, frame hold. hsync/vsync are ignored.
- en = 1, no sync markers (normal advance):
  - x < WIDTH-1: x <= x+1; y, frame hold.
  - x == WIDTH-1, y < HEIGHT-1: x <= 0, y <= y+1.
  - x == WIDTH-1, y == HEIGHT-1: x <= 0, y <= 0, frame <= frame+1.
- Sync handling (en = 1; see Optional Feature):
  - vsync has priority over hsync.
  - vsync: the current pixel is forced to be (0,0), so the next state is x <= 1, y <= 0. If the registered (x, y) was not already (0,0), frame <= frame+1 (an early frame restart counts as a frame). If it was (0,0), frame holds.
  - hsync without vsync: the current pixel is forced to be column 0, so the next state is x <= 1.
    - If registered x == 0: y holds (already aligned).
    - Otherwise: the line is treated as started early, and y advances as for a line wrap. If y == HEIGHT-1, y <= 0 and frame <= frame+1.
  - WIDTH == 1 is not supported, so x <= 1 is always legal.
- Arithmetic: unsigned 16-bit. Comparisons against WIDTH-1 / HEIGHT-1 are made at 16 bits. frame wraps 0xFFFF -> 0x0000 silently.
- Out-of-range state cannot occur from reset. If it does (e.g. an X-corrupted value), x > WIDTH-1 is treated as end of line and y > HEIGHT-1 as end of frame.
- Enable toggling mid-line or mid-frame must resume exactly where it stopped. No pixel is skipped or repeated.
- No handshake; single-cycle throughput, zero added latency: the outputs describe the current cycle's pixel.

Optional Feature:
- Macro LOCATION_SYNC_EN.
- Defined: hsync/vsync realignment behaves as specified above.
- Undefined: hsync and vsync are ignored (ports remain, unconnected internally). Counters free-run purely from WIDTH/HEIGHT and en.

Test Plan:
- Reset mid-frame: run to (2,1), assert reset asynchronously between edges -> x = 0, y = 0, frame = 0 immediately; first enabled cycle after release shows (0,0).
- Free-run, WIDTH = 4, HEIGHT = 3, en = 1 for 13 cycles -> sequence (0,0)..(3,0),(0,1)..(3,2), then (0,0) with frame = 1; eol high at x = 3; eof high only at (3,2).
- Enable gaps: en toggled 0/1 every 3 cycles for 24 cycles -> coordinates identical to a gap-free run of 12 enabled cycles; frame = 1.
- hsync early (LOCATION_SYNC_EN): at (2,1) assert hsync one cycle -> that cycle's pixel is column 0 of line 2; next cycle (1,2). hsync at x = 0 -> y unchanged, next x = 1.
- vsync early (LOCATION_SYNC_EN): at (1,2), frame = 0, assert vsync -> next (1,0), frame = 1. vsync at (0,0) -> frame unchanged. vsync + hsync together -> vsync behaviour.
- Frame counter wrap: force/preload frame = 0xFFFF, complete a frame -> frame = 0x0000. Without LOCATION_SYNC_EN, hsync/vsync pulses have no effect on x/y/frame.

Source files
------------

// File: rtl/pixel_location_generator_if.sv
// Pixel-stream control and coordinate bundle for pixel_location_generator.
// master: pixel source side (drives enable/sync). slave: the generator.
interface pixel_location_generator_if;
    logic        en;
    logic        hsync;
    logic        vsync;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] frame;
    logic        eol;
    logic        eof;

    modport master (
        output en, hsync, vsync,
        input  x, y, frame, eol, eof
    );

    modport slave (
        input  en, hsync, vsync,
        output x, y, frame, eol, eof
    );
endinterface

// File: rtl/pixel_location_generator.sv
// Raster-scan (x, y, frame) tracker for the streaming image pipeline.
// Macro LOCATION_SYNC_EN enables hsync/vsync realignment; otherwise the markers are ignored.
module pixel_location_generator #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480
) (
    input  logic                        clk,
    input  logic                        reset,
    pixel_location_generator_if.slave   bus
);

    localparam logic [15:0] LAST_X = 16'(WIDTH - 1);
    localparam logic [15:0] LAST_Y = 16'(HEIGHT - 1);

    logic [15:0] r_x;
    logic [15:0] r_y;
    logic [15:0] r_frame;

    logic [15:0] w_x_nxt;
    logic [15:0] w_y_nxt;
    logic [15:0] w_frame_nxt;
    logic        w_x_end;
    logic        w_y_end;

    // Out-of-range coordinates are treated as end of line / end of frame
    assign w_x_end = (r_x >= LAST_X);
    assign w_y_end = (r_y >= LAST_Y);

`ifndef LOCATION_SYNC_EN
    logic w_unused_sync;
    assign w_unused_sync = bus.hsync | bus.vsync;
`endif

    always_comb begin
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_frame_nxt = r_frame;
        if (bus.en) begin
            if (!w_x_end) begin
                w_x_nxt = r_x + 16'd1;
            end else begin
                w_x_nxt = '0;
                if (!w_y_end) begin
                    w_y_nxt = r_y + 16'd1;
                end else begin
                    w_y_nxt     = '0;
                    w_frame_nxt = r_frame + 16'd1;
                end
            end
`ifdef LOCATION_SYNC_EN
            // Markers override the normal advance; the marked pixel becomes x=0, so next x is 1
            if (bus.vsync) begin
                w_x_nxt = 16'd1;
                w_y_nxt = '0;
                if ((r_x != '0) || (r_y != '0)) begin
                    w_frame_nxt = r_frame + 16'd1;
                end else begin
                    w_frame_nxt = r_frame;
                end
            end else if (bus.hsync) begin
                w_x_nxt = 16'd1;
                if (r_x == '0) begin
                    w_y_nxt     = r_y;
                    w_frame_nxt = r_frame;
                end else if (!w_y_end) begin
                    w_y_nxt     = r_y + 16'd1;
                    w_frame_nxt = r_frame;
                end else begin
                    w_y_nxt     = '0;
                    w_frame_nxt = r_frame + 16'd1;
                end
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_x     <= '0;
            r_y     <= '0;
            r_frame <= '0;
        end else begin
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_frame <= w_frame_nxt;
        end
    end

    assign bus.x     = r_x;
    assign bus.y     = r_y;
    assign bus.frame = r_frame;
    assign bus.eol   = (r_x == LAST_X);
    assign bus.eof   = (r_x == LAST_X) && (r_y == LAST_Y);

endmodule

// File: tb/tb_pixel_location_generator.sv
// Directed bench for pixel_location_generator at WIDTH=4, HEIGHT=3.
// Sync-marker checks follow LOCATION_SYNC_EN; without it markers must have no effect.
module tb_pixel_location_generator;

    typedef struct {
        logic        en;
        logic        hs;
        logic        vs;
        logic [15:0] ex;
        logic [15:0] ey;
        logic [15:0] ef;
        logic        eeol;
        logic        eeof;
    } vec_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    pixel_location_generator_if bus ();

    pixel_location_generator #(
        .WIDTH  (4),
        .HEIGHT (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mkv(input logic e, input logic h, input logic v,
                                 input int x, input int y, input int f,
                                 input logic l, input logic o);
        vec_t r;
        r.en = e; r.hs = h; r.vs = v;
        r.ex = 16'(x); r.ey = 16'(y); r.ef = 16'(f);
        r.eeol = l; r.eeof = o;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [15:0] ex, input logic [15:0] ey,
                       input logic [15:0] ef, input logic el, input logic eo);
        n_checks++;
        if (bus.x !== ex || bus.y !== ey || bus.frame !== ef || bus.eol !== el || bus.eof !== eo) begin
            n_fail++;
            $display("FAIL %s: got x=%0d y=%0d frame=%0h eol=%b eof=%b, expected x=%0d y=%0d frame=%0h eol=%b eof=%b",
                     nm, bus.x, bus.y, bus.frame, bus.eol, bus.eof, ex, ey, ef, el, eo);
        end
    endtask

    task automatic step(input logic e, input logic h, input logic v);
        bus.en = e; bus.hsync = h; bus.vsync = v;
        @(posedge clk);
        #1;
        bus.en = 1'b0; bus.hsync = 1'b0; bus.vsync = 1'b0;
    endtask

    task automatic do_reset();
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    vec_t fr[13];

    initial begin
        int n;
        logic e;

        // Free-run table: inputs for this cycle, expected outputs seen in this cycle
        fr[0]  = mkv(1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
        fr[1]  = mkv(1'b1, 1'b0, 1'b0, 1, 0, 0, 1'b0, 1'b0);
        fr[2]  = mkv(1'b1, 1'b0, 1'b0, 2, 0, 0, 1'b0, 1'b0);
        fr[3]  = mkv(1'b1, 1'b0, 1'b0, 3, 0, 0, 1'b1, 1'b0);
        fr[4]  = mkv(1'b1, 1'b0, 1'b0, 0, 1, 0, 1'b0, 1'b0);
        fr[5]  = mkv(1'b1, 1'b0, 1'b0, 1, 1, 0, 1'b0, 1'b0);
        fr[6]  = mkv(1'b1, 1'b0, 1'b0, 2, 1, 0, 1'b0, 1'b0);
        fr[7]  = mkv(1'b1, 1'b0, 1'b0, 3, 1, 0, 1'b1, 1'b0);
        fr[8]  = mkv(1'b1, 1'b0, 1'b0, 0, 2, 0, 1'b0, 1'b0);
        fr[9]  = mkv(1'b1, 1'b0, 1'b0, 1, 2, 0, 1'b0, 1'b0);
        fr[10] = mkv(1'b1, 1'b0, 1'b0, 2, 2, 0, 1'b0, 1'b0);
        fr[11] = mkv(1'b1, 1'b0, 1'b0, 3, 2, 0, 1'b1, 1'b1);
        fr[12] = mkv(1'b0, 1'b0, 1'b0, 0, 0, 1, 1'b0, 1'b0);

        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        bus.en = 1'b0; bus.hsync = 1'b0; bus.vsync = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", 16'd0, 16'd0, 16'd0, 1'b0, 1'b0);
        reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            chk($sformatf("freerun[%0d]", i), fr[i].ex, fr[i].ey, fr[i].ef, fr[i].eeol, fr[i].eeof);
            step(fr[i].en, fr[i].hs, fr[i].vs);
        end

        // Enable gaps: position must track the count of enabled cycles only
        do_reset();
        n = 0;
        for (int k = 0; k < 24; k++) begin
            e = ((k / 3) % 2 == 0);
            chk($sformatf("gap[%0d]", k), fr[n].ex, fr[n].ey, fr[n].ef, fr[n].eeol, fr[n].eeof);
            step(e, 1'b0, 1'b0);
            if (e) n++;
        end
        chk("gap_final", 16'd0, 16'd0, 16'd1, 1'b0, 1'b0);

        // Asynchronous reset mid-frame at (2,1), frame 1
        do_reset();
        repeat (18) step(1'b1, 1'b0, 1'b0);
        chk("pre_async_reset", 16'd2, 16'd1, 16'd1, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_immediate", 16'd0, 16'd0, 16'd0, 1'b0, 1'b0);
        #1;
        reset = 1'b0;
        chk("first_after_reset", 16'd0, 16'd0, 16'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("second_after_reset", 16'd0, 16'd0, 16'd0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("advance_after_reset", 16'd1, 16'd0, 16'd0, 1'b0, 1'b0);

`ifdef LOCATION_SYNC_EN
        do_reset();
        repeat (6) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("hsync_early", 16'd1, 16'd2, 16'd0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("before_hsync_last_line", 16'd3, 16'd2, 16'd0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        chk("hsync_last_line", 16'd1, 16'd0, 16'd1, 1'b0, 1'b0);
        repeat (3) step(1'b1, 1'b0, 1'b0);
        chk("before_hsync_x0", 16'd0, 16'd1, 16'd1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("hsync_x0", 16'd1, 16'd1, 16'd1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        chk("sync_ignored_en0", 16'd1, 16'd1, 16'd1, 1'b0, 1'b0);

        do_reset();
        repeat (9) step(1'b1, 1'b0, 1'b0);
        chk("before_vsync", 16'd1, 16'd2, 16'd0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        chk("vsync_early", 16'd1, 16'd0, 16'd1, 1'b0, 1'b0);
        do_reset();
        step(1'b1, 1'b0, 1'b1);
        chk("vsync_at_origin", 16'd1, 16'd0, 16'd0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        chk("vsync_hsync_priority", 16'd1, 16'd0, 16'd1, 1'b0, 1'b0);
`else
        do_reset();
        repeat (5) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("hsync_no_effect", 16'd2, 16'd1, 16'd0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        chk("vsync_no_effect", 16'd3, 16'd1, 16'd0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        chk("both_no_effect", 16'd0, 16'd2, 16'd0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        chk("sync_ignored_en0", 16'd0, 16'd2, 16'd0, 1'b0, 1'b0);
`endif

        // Frame counter wrap from a preloaded 0xFFFF
        do_reset();
        force dut.r_frame = 16'hFFFF;
        #1;
        release dut.r_frame;
        #1;
        chk("frame_preload", 16'd0, 16'd0, 16'hFFFF, 1'b0, 1'b0);
        repeat (11) step(1'b1, 1'b0, 1'b0);
        chk("frame_before_wrap", 16'd3, 16'd2, 16'hFFFF, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        chk("frame_wrap", 16'd0, 16'd0, 16'h0000, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
